// File: rtl/lsu_sramlike_bridge_if.sv
// LSU request/response and SRAM-like bus signals grouped for lsu_sramlike_bridge.
// The bridge takes the master modport; the LSU/slave environment takes the slave modport.
interface lsu_sramlike_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write_en;
    logic [3:0]  req_strobe;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_addr, req_write_en, req_strobe, req_data,
        input  resp_ready, bus_addr_ok, bus_data_ok, bus_rdata,
        output req_ready, resp_valid, resp_data,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata
    );

    modport slave (
        output req_valid, req_addr, req_write_en, req_strobe, req_data,
        output resp_ready, bus_addr_ok, bus_data_ok, bus_rdata,
        input  req_ready, resp_valid, resp_data,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata
    );
endinterface

// File: rtl/lsu_sramlike_bridge.sv
// LSU valid/ready to SRAM-like (req/addr_ok/data_ok) bridge with an in-order
// transaction tag FIFO and a read-data queue holding loads until the LSU takes them.
module lsu_sramlike_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned RDQ_DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    lsu_sramlike_bridge_if.master  bif,
    output logic                   busy,
    output logic                   proto_err
);
    localparam int unsigned OW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned RW  = $clog2(RDQ_DEPTH) + 1;
    localparam int unsigned TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned RPW = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
    localparam int unsigned SW  = ((OW > RW) ? OW : RW) + 1;

    logic           tagMem [MAX_OUTSTANDING];
    logic [TPW-1:0] tagWr, tagRd;
    logic [OW-1:0]  tagCnt, readOutCnt;
    logic [31:0]    rdqMem [RDQ_DEPTH];
    logic [RPW-1:0] rdqWr, rdqRd;
    logic [RW-1:0]  rdqCnt;

    logic       canIssue, accept, readAccept, tagPop, rdqPush, rdqPop;
    logic [1:0] lowBits;
    logic [1:0] unusedLowAddr;

    function automatic logic [TPW-1:0] tagNext(input logic [TPW-1:0] p);
        return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
    endfunction

    function automatic logic [RPW-1:0] rdqNext(input logic [RPW-1:0] p);
        return (p == RPW'(RDQ_DEPTH - 1)) ? '0 : p + RPW'(1);
    endfunction

    // Loads reserve a read-queue slot at issue time, so a returning load can never overflow it.
    assign canIssue = !rst && (tagCnt < OW'(MAX_OUTSTANDING)) &&
                      (bif.req_write_en || (SW'(readOutCnt) + SW'(rdqCnt) < SW'(RDQ_DEPTH)));

    assign bif.bus_req   = bif.req_valid && canIssue;
    assign bif.req_ready = canIssue && bif.bus_addr_ok;
    assign bif.bus_wr    = bif.req_write_en;
    assign bif.bus_wdata = bif.req_data;
    assign accept        = bif.bus_req && bif.bus_addr_ok;
    assign readAccept    = accept && !bif.req_write_en;
    assign unusedLowAddr = bif.req_addr[1:0];

    always_comb begin
        bif.bus_size = 2'd2;
        lowBits      = 2'b00;
        if (bif.req_write_en) begin
            case (bif.req_strobe)
                4'b0001: begin bif.bus_size = 2'd0; lowBits = 2'b00; end
                4'b0010: begin bif.bus_size = 2'd0; lowBits = 2'b01; end
                4'b0100: begin bif.bus_size = 2'd0; lowBits = 2'b10; end
                4'b1000: begin bif.bus_size = 2'd0; lowBits = 2'b11; end
                4'b0011: begin bif.bus_size = 2'd1; lowBits = 2'b00; end
                4'b1100: begin bif.bus_size = 2'd1; lowBits = 2'b10; end
                default: begin bif.bus_size = 2'd2; lowBits = 2'b00; end
            endcase
        end
        bif.bus_addr = {bif.req_addr[31:2], lowBits};
    end

    // Tag count is the registered value, so a same-cycle accept never satisfies this data_ok.
    assign tagPop  = bif.bus_data_ok && (tagCnt != '0);
    assign rdqPush = tagPop && !tagMem[tagRd];
    assign rdqPop  = (rdqCnt != '0) && bif.resp_ready;

    assign bif.resp_valid = (rdqCnt != '0);
    assign bif.resp_data  = bif.resp_valid ? rdqMem[rdqRd] : '0;
    assign busy           = (tagCnt != '0) || (rdqCnt != '0);

    always_ff @(posedge clk) begin
        if (accept)  tagMem[tagWr] <= bif.req_write_en;
        if (rdqPush) rdqMem[rdqWr] <= bif.bus_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tagWr      <= '0;
            tagRd      <= '0;
            tagCnt     <= '0;
            readOutCnt <= '0;
            rdqWr      <= '0;
            rdqRd      <= '0;
            rdqCnt     <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (accept)  tagWr <= tagNext(tagWr);
            if (tagPop)  tagRd <= tagNext(tagRd);
            if (rdqPush) rdqWr <= rdqNext(rdqWr);
            if (rdqPop)  rdqRd <= rdqNext(rdqRd);
            if (bif.bus_data_ok && (tagCnt == '0)) proto_err <= 1'b1;

            case ({accept, tagPop})
                2'b10:   tagCnt <= tagCnt + OW'(1);
                2'b01:   tagCnt <= tagCnt - OW'(1);
                default: tagCnt <= tagCnt;
            endcase
            case ({readAccept, rdqPush})
                2'b10:   readOutCnt <= readOutCnt + OW'(1);
                2'b01:   readOutCnt <= readOutCnt - OW'(1);
                default: readOutCnt <= readOutCnt;
            endcase
            case ({rdqPush, rdqPop})
                2'b10:   rdqCnt <= rdqCnt + RW'(1);
                2'b01:   rdqCnt <= rdqCnt - RW'(1);
                default: rdqCnt <= rdqCnt;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_sramlike_bridge.sv
// Testbench for lsu_sramlike_bridge: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the bridge's externally visible behaviour.
module tb_lsu_sramlike_bridge;
    localparam int MAXO = 2;
    localparam int RDQ  = 2;

    logic clk;
    logic rst;
    logic busy;
    logic protoErr;
    int   checks = 0;
    int   errors = 0;

    lsu_sramlike_bridge_if bif();

    lsu_sramlike_bridge #(.MAX_OUTSTANDING(MAXO), .RDQ_DEPTH(RDQ)) dut (
        .clk(clk), .rst(rst), .bif(bif), .busy(busy), .proto_err(protoErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-order list of accepted transactions (1 = write) and delivered load data.
    bit          pendQ[$];
    logic [31:0] respQ[$];
    int          pendReads = 0;
    bit          expProtoErr = 0;

    function automatic bit modelCanIssue(input logic wr);
        return !rst && (pendQ.size() < MAXO) && (wr || (pendReads + respQ.size() < RDQ));
    endfunction

    function automatic void expMap(input logic wr, input logic [3:0] s, input logic [31:0] a,
                                   output logic [1:0] sz, output logic [31:0] ea);
        sz = 2'd2;
        ea = a & ~32'h3;
        if (wr) begin
            if (s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8) begin
                sz = 2'd0;
                ea = (a & ~32'h3) | 32'($clog2(s));
            end else if (s == 4'd3) begin
                sz = 2'd1;
            end else if (s == 4'd12) begin
                sz = 2'd1;
                ea = (a & ~32'h3) | 32'd2;
            end
        end
    endfunction

    // Advance one clock and update the model from the inputs applied this cycle.
    task automatic tick();
        bit          acc, pop, dok, wr, t;
        logic [31:0] rd;
        wr  = bif.req_write_en;
        acc = bif.req_valid && bif.bus_addr_ok && modelCanIssue(wr);
        pop = (respQ.size() > 0) && bif.resp_ready;
        dok = bif.bus_data_ok;
        rd  = bif.bus_rdata;
        @(posedge clk);
        if (rst) begin
            pendQ.delete();
            respQ.delete();
            pendReads   = 0;
            expProtoErr = 0;
        end else begin
            if (pop) void'(respQ.pop_front());
            if (dok) begin
                if (pendQ.size() == 0) expProtoErr = 1;
                else begin
                    t = pendQ.pop_front();
                    if (!t) begin
                        pendReads--;
                        respQ.push_back(rd);
                    end
                end
            end
            if (acc) begin
                pendQ.push_back(wr);
                if (!wr) pendReads++;
            end
        end
        #1;
    endtask

    task automatic idleInputs();
        bif.req_valid    = 0;
        bif.req_addr     = '0;
        bif.req_write_en = 0;
        bif.req_strobe   = '0;
        bif.req_data     = '0;
        bif.resp_ready   = 0;
        bif.bus_addr_ok  = 0;
        bif.bus_data_ok  = 0;
        bif.bus_rdata    = '0;
    endtask

    task automatic setReq(input logic wr, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        bif.req_valid    = 1;
        bif.req_write_en = wr;
        bif.req_addr     = a;
        bif.req_strobe   = s;
        bif.req_data     = d;
    endtask

    task automatic test_reset();
        rst = 1;
        idleInputs();
        tick();
        tick();
        #1;
        checks += 5;
        if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bif.resp_valid); end
        if (bif.bus_req !== 1'b0)    begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bif.bus_req); end
        if (bif.req_ready !== 1'b0)  begin errors++; $display("FAIL reset_req_ready: got %b expected 0", bif.req_ready); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (protoErr !== 1'b0)       begin errors++; $display("FAIL reset_proto_err: got %b expected 0", protoErr); end
        rst = 0;
        tick();
    endtask

    task automatic test_load();
        setReq(0, 32'h0000_1004, 4'h0, '0);
        bif.bus_addr_ok = 1;
        #1;
        checks += 5;
        if (bif.bus_req !== 1'b1)          begin errors++; $display("FAIL lw_bus_req: got %b expected 1", bif.bus_req); end
        if (bif.bus_wr !== 1'b0)           begin errors++; $display("FAIL lw_bus_wr: got %b expected 0", bif.bus_wr); end
        if (bif.bus_size !== 2'd2)         begin errors++; $display("FAIL lw_size: got %0d expected 2", bif.bus_size); end
        if (bif.bus_addr !== 32'h1004)     begin errors++; $display("FAIL lw_addr: got %h expected 00001004", bif.bus_addr); end
        if (bif.req_ready !== 1'b1)        begin errors++; $display("FAIL lw_req_ready: got %b expected 1", bif.req_ready); end
        tick();
        idleInputs();
        tick();
        bif.bus_data_ok = 1;
        bif.bus_rdata   = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_same_cycle_resp: got %b expected 0", bif.resp_valid); end
        tick();
        idleInputs();
        #1;
        checks += 2;
        if (bif.resp_valid !== 1'b1)          begin errors++; $display("FAIL lw_resp_valid: got %b expected 1", bif.resp_valid); end
        if (bif.resp_data !== 32'hDEAD_BEEF)  begin errors++; $display("FAIL lw_resp_data: got %h expected deadbeef", bif.resp_data); end
        bif.resp_ready = 1;
        tick();
        idleInputs();
        #1;
        checks += 2;
        if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL lw_resp_drained: got %b expected 0", bif.resp_valid); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL lw_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_store();
        setReq(1, 32'h0000_2003, 4'b1000, 32'hAB00_0000);
        bif.bus_addr_ok = 1;
        #1;
        checks += 4;
        if (bif.bus_wr !== 1'b1)            begin errors++; $display("FAIL sb_bus_wr: got %b expected 1", bif.bus_wr); end
        if (bif.bus_size !== 2'd0)          begin errors++; $display("FAIL sb_size: got %0d expected 0", bif.bus_size); end
        if (bif.bus_addr !== 32'h2003)      begin errors++; $display("FAIL sb_addr: got %h expected 00002003", bif.bus_addr); end
        if (bif.bus_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL sb_wdata: got %h expected ab000000", bif.bus_wdata); end
        tick();
        idleInputs();
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL sb_busy_pending: got %b expected 1", busy); end
        bif.bus_data_ok = 1;
        tick();
        idleInputs();
        #1;
        checks += 2;
        if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL sb_no_resp: got %b expected 0", bif.resp_valid); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL sb_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_size_map();
        logic [3:0]  strobes [8] = '{4'b1100, 4'b0110, 4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b1111, 4'b1010};
        logic [1:0]  expSize [8] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
        logic [31:0] expAddr [8] = '{32'h3002, 32'h3000, 32'h3000, 32'h3001, 32'h3002, 32'h3000, 32'h3000, 32'h3000};
        for (int i = 0; i < 8; i++) begin
            setReq(1, 32'h0000_3002, strobes[i], 32'h1234_5678);
            #1;
            checks += 2;
            if (bif.bus_size !== expSize[i]) begin errors++; $display("FAIL map_size[%b]: got %0d expected %0d", strobes[i], bif.bus_size, expSize[i]); end
            if (bif.bus_addr !== expAddr[i]) begin errors++; $display("FAIL map_addr[%b]: got %h expected %h", strobes[i], bif.bus_addr, expAddr[i]); end
        end
        idleInputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        r1 = $urandom;
        r2 = $urandom;
        bif.bus_addr_ok = 1;
        setReq(0, 32'h0000_4000, 4'h0, '0);
        tick();
        setReq(0, 32'h0000_4004, 4'h0, '0);
        tick();
        setReq(0, 32'h0000_4008, 4'h0, '0);
        #1;
        checks += 2;
        if (bif.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_third_held: got %b expected 0", bif.req_ready); end
        if (bif.bus_req !== 1'b0)   begin errors++; $display("FAIL b2b_third_bus_req: got %b expected 0", bif.bus_req); end
        bif.req_valid   = 0;
        bif.bus_data_ok = 1;
        bif.bus_rdata   = r1;
        tick();
        bif.bus_rdata   = r2;
        tick();
        bif.bus_data_ok = 0;
        bif.req_valid   = 1;
        #1;
        checks += 3;
        if (bif.req_ready !== 1'b0)  begin errors++; $display("FAIL b2b_rdq_full_held: got %b expected 0", bif.req_ready); end
        if (bif.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp_valid: got %b expected 1", bif.resp_valid); end
        if (bif.resp_data !== r1)    begin errors++; $display("FAIL b2b_first: got %h expected %h", bif.resp_data, r1); end
        bif.req_valid  = 0;
        bif.resp_ready = 1;
        tick();
        #1;
        checks++;
        if (bif.resp_data !== r2) begin errors++; $display("FAIL b2b_second: got %h expected %h", bif.resp_data, r2); end
        tick();
        #1;
        checks++;
        if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", bif.resp_valid); end
        idleInputs();
        tick();
    endtask

    task automatic test_addr_ok_stall();
        setReq(0, 32'h0000_5010, 4'h0, '0);
        bif.bus_addr_ok = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks += 3;
            if (bif.req_ready !== 1'b0)       begin errors++; $display("FAIL stall_req_ready[%0d]: got %b expected 0", c, bif.req_ready); end
            if (bif.bus_req !== 1'b1)         begin errors++; $display("FAIL stall_bus_req[%0d]: got %b expected 1", c, bif.bus_req); end
            if (bif.bus_addr !== 32'h5010)    begin errors++; $display("FAIL stall_addr[%0d]: got %h expected 00005010", c, bif.bus_addr); end
            tick();
        end
        bif.bus_addr_ok = 1;
        #1;
        checks++;
        if (bif.req_ready !== 1'b1) begin errors++; $display("FAIL stall_accept: got %b expected 1", bif.req_ready); end
        tick();
        idleInputs();
        bif.bus_data_ok = 1;
        tick();
        idleInputs();
        bif.resp_ready = 1;
        tick();
        idleInputs();
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_random();
        logic [1:0]  eSize;
        logic [31:0] eAddr;
        bit          eReq, eRdy;
        idleInputs();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!bif.req_valid) begin
                if ($urandom_range(0, 9) < 7)
                    setReq(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom);
            end
            bif.bus_addr_ok = ($urandom_range(0, 3) != 0);
            bif.bus_data_ok = (pendQ.size() > 0) && ($urandom_range(0, 1) == 1);
            bif.bus_rdata   = $urandom;
            bif.resp_ready  = ($urandom_range(0, 2) != 0);
            #1;
            expMap(bif.req_write_en, bif.req_strobe, bif.req_addr, eSize, eAddr);
            eReq = bif.req_valid && modelCanIssue(bif.req_write_en);
            eRdy = modelCanIssue(bif.req_write_en) && bif.bus_addr_ok;
            checks += 8;
            if (bif.bus_req !== eReq)     begin errors++; $display("FAIL rnd_bus_req@%0d: got %b expected %b", cyc, bif.bus_req, eReq); end
            if (bif.req_ready !== eRdy)   begin errors++; $display("FAIL rnd_req_ready@%0d: got %b expected %b", cyc, bif.req_ready, eRdy); end
            if (bif.bus_size !== eSize)   begin errors++; $display("FAIL rnd_size@%0d: got %0d expected %0d", cyc, bif.bus_size, eSize); end
            if (bif.bus_addr !== eAddr)   begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", cyc, bif.bus_addr, eAddr); end
            if (bif.bus_wdata !== bif.req_data) begin errors++; $display("FAIL rnd_wdata@%0d: got %h expected %h", cyc, bif.bus_wdata, bif.req_data); end
            if (bif.resp_valid !== (respQ.size() > 0)) begin errors++; $display("FAIL rnd_resp_valid@%0d: got %b expected %b", cyc, bif.resp_valid, respQ.size() > 0); end
            if (busy !== (pendQ.size() > 0 || respQ.size() > 0)) begin errors++; $display("FAIL rnd_busy@%0d: got %b", cyc, busy); end
            if (protoErr !== expProtoErr) begin errors++; $display("FAIL rnd_proto_err@%0d: got %b expected %b", cyc, protoErr, expProtoErr); end
            if (respQ.size() > 0) begin
                checks++;
                if (bif.resp_data !== respQ[0]) begin errors++; $display("FAIL rnd_resp_data@%0d: got %h expected %h", cyc, bif.resp_data, respQ[0]); end
            end
            if (eRdy && bif.req_valid) begin
                tick();
                bif.req_valid = 0;
            end else begin
                tick();
            end
        end
        idleInputs();
        bif.resp_ready = 1;
        for (int c = 0; c < 40 && (pendQ.size() > 0 || respQ.size() > 0); c++) begin
            bif.bus_data_ok = (pendQ.size() > 0);
            bif.bus_rdata   = $urandom;
            tick();
        end
        idleInputs();
        #1;
        checks++;
        if (busy !== 1'b0 || pendQ.size() != 0 || respQ.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain: busy %b model pend %0d resp %0d, expected all empty", busy, pendQ.size(), respQ.size());
        end
        tick();
    endtask

    task automatic test_spurious();
        rst = 1;
        idleInputs();
        tick();
        rst = 0;
        bif.bus_data_ok = 1;
        bif.bus_rdata   = 32'hFFFF_FFFF;
        tick();
        idleInputs();
        #1;
        checks += 3;
        if (protoErr !== 1'b1)       begin errors++; $display("FAIL spurious_proto_err: got %b expected 1", protoErr); end
        if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL spurious_resp_valid: got %b expected 0", bif.resp_valid); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL spurious_busy: got %b expected 0", busy); end
        tick();
        #1;
        checks++;
        if (protoErr !== 1'b1) begin errors++; $display("FAIL spurious_sticky: got %b expected 1", protoErr); end
    endtask

    task automatic test_reset_mid();
        bif.bus_addr_ok = 1;
        setReq(0, 32'h0000_6000, 4'h0, '0);
        tick();
        setReq(0, 32'h0000_6004, 4'h0, '0);
        tick();
        idleInputs();
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1;
        tick();
        #1;
        checks += 6;
        if (bif.bus_req !== 1'b0)    begin errors++; $display("FAIL mid_bus_req: got %b expected 0", bif.bus_req); end
        if (bif.req_ready !== 1'b0)  begin errors++; $display("FAIL mid_req_ready: got %b expected 0", bif.req_ready); end
        if (bif.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_valid: got %b expected 0", bif.resp_valid); end
        if (bif.resp_data !== 32'h0) begin errors++; $display("FAIL mid_resp_data: got %h expected 0", bif.resp_data); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        if (protoErr !== 1'b0)       begin errors++; $display("FAIL mid_proto_err: got %b expected 0", protoErr); end
        rst = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_size_map();
        test_back_to_back();
        test_addr_ok_stall();
        test_random();
        test_spurious();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
